// File: rtl/frame_fill.sv
// rtl/frame_fill.sv - tile-map renderer that fills the back frame buffer one pixel per clk
module frame_fill #(
  parameter int          ROW_LEN   = 264,
  parameter int          NUM_ROWS  = 240,
  parameter int          MAP_COLS  = 33,
  parameter logic [15:0] PARK_ADDR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        buf_sel,
  output logic [9:0]  map_addr,
  input  logic [7:0]  map_data,
  output logic [13:0] pat_addr,
  input  logic [7:0]  pat_data,
  output logic [15:0] addrWrite,
  output logic [7:0]  dataWrite,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [7:0] X_LAST   = 8'(NUM_ROWS - 1);
  localparam logic [8:0] Y_LAST   = 9'(ROW_LEN - 1);
  localparam logic [9:0] MAP_STEP = 10'(MAP_COLS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic        buf_sel_q;
  logic        toggle, abort;
  logic [7:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [15:0] lin_q, lin_d;
  logic [9:0]  row_q, row_d;    // (x>>3)*MAP_COLS, stepped instead of multiplied
  logic        drain_q, drain_d;

  // S1 / S2 pipeline registers
  logic        v1_q;
  logic [2:0]  x1_q, y1_q;
  logic [15:0] lin1_q;
  logic        v2_q;
  logic [15:0] addr_q;

  assign toggle     = buf_sel ^ buf_sel_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign abort      = toggle && busy;
  assign frame_done = (state_q == DONE);
  assign map_addr   = row_q + {4'd0, y_q[8:3]};
  assign pat_addr   = v1_q ? {map_data, x1_q, y1_q} : 14'd0;
  assign addrWrite  = addr_q;
  assign dataWrite  = v2_q ? pat_data : 8'd0;

  // State, edge-detect and scan counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      buf_sel_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      lin_q     <= '0;
      row_q     <= '0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_sel_q <= buf_sel;
      x_q       <= x_d;
      y_q       <= y_d;
      lin_q     <= lin_d;
      row_q     <= row_d;
      drain_q   <= drain_d;
    end
  end

  // Next state and scan order; counters sit at zero outside RUN
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    lin_d   = lin_q;
    row_d   = row_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (toggle) state_d = RUN;
      end
      RUN: begin
        if (toggle || (x_q == X_LAST && y_q == Y_LAST)) begin
          x_d     = '0;
          y_d     = '0;
          lin_d   = '0;
          row_d   = '0;
          drain_d = 1'b0;
          state_d = toggle ? RUN : DRAIN;
        end else begin
          lin_d = lin_q + 16'd1;
          if (y_q == Y_LAST) begin
            y_d = '0;
            x_d = x_q + 8'd1;
            if (x_q[2:0] == 3'd7) row_d = row_q + MAP_STEP;
          end else begin
            y_d = y_q + 9'd1;
          end
        end
      end
      DRAIN: begin
        if (toggle)       state_d = RUN;
        else if (drain_q) state_d = DONE;
        else              drain_d = 1'b1;
      end
      DONE: begin
        state_d = toggle ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-stage pixel pipeline aligned with the two sync ROM reads; abort flushes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      x1_q   <= '0;
      y1_q   <= '0;
      lin1_q <= '0;
      v2_q   <= 1'b0;
      addr_q <= PARK_ADDR;
    end else begin
      v1_q   <= (state_q == RUN) && !abort;
      x1_q   <= x_q[2:0];
      y1_q   <= y_q[2:0];
      lin1_q <= lin_q;
      v2_q   <= v1_q && !abort;
      addr_q <= (v1_q && !abort) ? lin1_q : PARK_ADDR;
    end
  end

endmodule
